filt_ppi_tdm: RTL

- Single-clock, time-multiplexed polyphase interpolator. One shared MAC computes the interpolation-factor output phases for each accepted input sample.
- Interpolation factor is selectable at run time. Coefficients are loaded through a write port.
- Input and output use valid/ready handshakes. Sits between an upstream sample source and a downstream FIFO/DAC path, replacing the parallel multiply-add plus commutator structure.

---
 rtl/filt_ppi_tdm.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/filt_ppi_tdm.sv
// Time-multiplexed polyphase interpolator: one shared MAC produces every output phase.
// Define FILT_PPI_TDM_SAT_EN to saturate the output instead of wrapping it.
module filt_ppi_tdm #(
  parameter int unsigned gp_idata_width = 8,
  parameter int unsigned gp_coeff_width = 16,
  parameter int unsigned gp_taps        = 4,
  parameter int unsigned gp_max_factor  = 4,
  parameter int unsigned gp_odata_width = 16,
  parameter int unsigned gp_out_shift   = 0,
  localparam int unsigned FactW  = $clog2(gp_max_factor + 1),
  localparam int unsigned Depth  = gp_taps * gp_max_factor,
  localparam int unsigned AddrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned PhaseW = (gp_max_factor > 1) ? $clog2(gp_max_factor) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [FactW-1:0]          i_factor,
  input  logic                      i_coeff_we,
  input  logic [AddrW-1:0]          i_coeff_addr,
  input  logic [gp_coeff_width-1:0] i_coeff_data,
  input  logic                      i_flush,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [gp_idata_width-1:0] i_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [gp_odata_width-1:0] o_data,
  output logic [PhaseW-1:0]         o_phase,
  output logic                      o_last
);

  localparam int unsigned TapW  = (gp_taps > 1) ? $clog2(gp_taps) : 1;
  localparam int unsigned ProdW = gp_idata_width + gp_coeff_width;
  localparam int unsigned AccW  = ProdW + ((gp_taps > 1) ? $clog2(gp_taps) : 0);
  localparam int unsigned ExtW  = (AccW > gp_odata_width) ? AccW : gp_odata_width;

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                           state_q, state_d;
  logic [FactW-1:0]                 fact_q, fact_d;
  logic [PhaseW-1:0]                phase_q, phase_d;
  logic [TapW-1:0]                  tap_q, tap_d;
  logic signed [AccW-1:0]           acc_q, acc_d;
  logic signed [gp_idata_width-1:0] x_q [gp_taps];
  logic signed [gp_idata_width-1:0] x_d [gp_taps];
  logic signed [gp_coeff_width-1:0] h_q [Depth];

  logic                             coeff_wr;
  logic                             last_tap;
  logic                             last_phase;
  logic [FactW-1:0]                 fact_in;
  logic [31:0]                      coeff_idx;
  logic signed [gp_coeff_width-1:0] coeff_sel;
  logic signed [gp_idata_width-1:0] x_sel;
  logic signed [ProdW-1:0]          prod;
  logic signed [AccW-1:0]           prod_ext;
  logic signed [AccW-1:0]           acc_shift;
  logic signed [ExtW-1:0]           acc_ext;

  // Factor 0 behaves as 1; anything above the maximum is clamped.
  always_comb begin
    if (i_factor == '0) begin
      fact_in = FactW'(1);
    end else if (32'(i_factor) > gp_max_factor) begin
      fact_in = FactW'(gp_max_factor);
    end else begin
      fact_in = i_factor;
    end
  end

  assign o_ready    = (state_q == StIdle) && !i_flush;
  assign coeff_wr   = (state_q == StIdle) && i_coeff_we && (32'(i_coeff_addr) < Depth);
  assign last_tap   = (32'(tap_q) == gp_taps - 1);
  assign last_phase = (32'(phase_q) + 32'd1 == 32'(fact_q));

  // Polyphase tap t of phase p uses h[t*F + p].
  assign coeff_idx = 32'(tap_q) * 32'(fact_q) + 32'(phase_q);
  assign coeff_sel = h_q[AddrW'(coeff_idx)];
  assign x_sel     = x_q[tap_q];
  assign prod      = ProdW'(x_sel) * ProdW'(coeff_sel);
  assign prod_ext  = AccW'(prod);

  always_comb begin
    state_d = state_q;
    fact_d  = fact_q;
    phase_d = phase_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    x_d     = x_q;
    unique case (state_q)
      StIdle: begin
        if (i_flush) begin
          for (int unsigned t = 0; t < gp_taps; t++) begin
            x_d[t] = '0;
          end
        end else if (i_valid) begin
          x_d[0] = i_data;
          for (int unsigned t = 1; t < gp_taps; t++) begin
            x_d[t] = x_q[t-1];
          end
          fact_d  = fact_in;
          phase_d = '0;
          tap_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = (tap_q == '0) ? prod_ext : acc_q + prod_ext;
        if (last_tap) begin
          tap_d   = '0;
          state_d = StOut;
        end else begin
          tap_d = tap_q + TapW'(1);
        end
      end
      StOut: begin
        if (i_ready) begin
          if (last_phase) begin
            state_d = StIdle;
          end else begin
            phase_d = phase_q + PhaseW'(1);
            state_d = StMac;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      fact_q  <= FactW'(1);
      phase_q <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      for (int unsigned t = 0; t < gp_taps; t++) begin
        x_q[t] <= '0;
      end
    end else begin
      state_q <= state_d;
      fact_q  <= fact_d;
      phase_q <= phase_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < Depth; k++) begin
        h_q[k] <= '0;
      end
    end else if (coeff_wr) begin
      h_q[i_coeff_addr] <= i_coeff_data;
    end
  end

  assign acc_shift = acc_q >>> gp_out_shift;
  assign acc_ext   = ExtW'(acc_shift);

`ifdef FILT_PPI_TDM_SAT_EN
  logic [ExtW-gp_odata_width:0] acc_upper;
  assign acc_upper = acc_ext[ExtW-1:gp_odata_width-1];

  // Bits above the output sign bit must all match the sign, otherwise clip.
  always_comb begin
    o_data = gp_odata_width'(acc_ext);
    if (!(&acc_upper) && (|acc_upper)) begin
      o_data = acc_ext[ExtW-1] ? {1'b1, {(gp_odata_width-1){1'b0}}}
                               : {1'b0, {(gp_odata_width-1){1'b1}}};
    end
  end
`else
  assign o_data = gp_odata_width'(acc_ext);
`endif

  assign o_valid = (state_q == StOut);
  assign o_phase = phase_q;
  assign o_last  = (state_q == StOut) && last_phase;

endmodule
